// File: rtl/gray_seq_pkg.sv
// Shared state encoding, default width and the one-bit-step helper for the Gray sweep controller.
package gray_seq_pkg;

  localparam int WIDTH_DEF = 4;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // True when exactly one bit is set; callers zero-extend narrower codes.
  function automatic logic single_bit_diff(input logic [15:0] diff);
    return (diff != 16'd0) && ((diff & (diff - 16'd1)) == 16'd0);
  endfunction

endpackage

// File: rtl/gray_seq_ctrl_b2g.sv
// Purely combinational binary-to-reflected-Gray converter; no state, no handshake.
module binary_to_gray
  import gray_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_seq_ctrl.sv
// Sweeps lo..hi (wrapping) presenting binary and Gray beats; first beat the cycle after start, held while out_ready=0.
// Optional GRAY_SEQ_CHECK_EN adds a sticky chk_err flag for non-unit Gray steps between transferred beats.
module gray_seq_ctrl
  import gray_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             busy,
  output logic             done
`ifdef GRAY_SEQ_CHECK_EN
  ,
  output logic             chk_err
`endif
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] gray_q, gray_d;

  // Converting the next value lets the Gray register land on the same edge as cur_q.
  binary_to_gray #(.WIDTH(WIDTH)) u_b2g (
    .bin_i  (cur_d),
    .gray_o (gray_d)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    hi_d    = hi_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cur_d   = lo;
          hi_d    = hi;
        end
      end
      ST_RUN: begin
        if (out_ready) begin
          if (cur_q == hi_q) state_d = ST_DONE;
          else               cur_d   = cur_q + WIDTH'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      hi_q    <= '0;
      gray_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      hi_q    <= hi_d;
      gray_q  <= gray_d;
    end
  end

  assign out_valid = (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign bin_out   = cur_q;
  assign gray_out  = gray_q;

`ifdef GRAY_SEQ_CHECK_EN
  logic             xfer;
  logic [WIDTH-1:0] prev_gray_q;
  logic             have_prev_q;
  logic             chk_err_q;

  assign xfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_gray_q <= '0;
      have_prev_q <= 1'b0;
      chk_err_q   <= 1'b0;
    end else if ((state_q == ST_IDLE) && start) begin
      have_prev_q <= 1'b0;
      chk_err_q   <= 1'b0;
    end else if (xfer) begin
      prev_gray_q <= gray_q;
      have_prev_q <= 1'b1;
      if (have_prev_q && !single_bit_diff(16'(prev_gray_q ^ gray_q))) chk_err_q <= 1'b1;
    end
  end

  assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Scoreboard bench: stimulus queues expected beats from a table-built Gray model, an independent monitor pops and compares.
module tb_gray_seq_ctrl;

  localparam int W = 4;
  localparam int N = 1 << W;

  logic         clk = 1'b0;
  logic         rst, start, out_ready;
  logic [W-1:0] lo, hi;
  logic         out_valid, busy, done;
  logic [W-1:0] bin_out, gray_out;
`ifdef GRAY_SEQ_CHECK_EN
  logic         chk_err;
`endif

  always #5 clk = ~clk;

  gray_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .lo        (lo),
    .hi        (hi),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .bin_out   (bin_out),
    .gray_out  (gray_out),
    .busy      (busy),
    .done      (done)
`ifdef GRAY_SEQ_CHECK_EN
    ,
    .chk_err   (chk_err)
`endif
  );

  typedef struct {
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    bit           last;
  } beat_t;

  beat_t        exp_q[$];
  beat_t        e;
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] gray_tab [N];
  int           rdy_mode = 0;
  int           stall_cnt = 0;
  bit           exp_done = 0;
  bit           hold_vld = 0;
  logic [W-1:0] hold_bin, hold_gray;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reflected Gray code built by mirroring, independent of the xor formula.
  task automatic build_gray_tab();
    gray_tab[0] = '0;
    for (int n = 0; n < W; n++)
      for (int i = 0; i < (1 << n); i++)
        gray_tab[(1 << n) + i] = W'((1 << n) | int'(gray_tab[(1 << n) - 1 - i]));
  endtask

  task automatic push_sweep(input logic [W-1:0] l, input logic [W-1:0] h);
    int v;
    v = int'(l);
    forever begin
      exp_q.push_back('{bin: W'(v), gray: gray_tab[v], last: (v == int'(h))});
      if (v == int'(h)) break;
      v = (v + 1) % N;
    end
  endtask

  task automatic do_start(input logic [W-1:0] l, input logic [W-1:0] h);
    lo = l; hi = h; start = 1'b1;
    push_sweep(l, h);
    @(posedge clk); #1;
    start = 1'b0;
    lo = W'($urandom);
    hi = W'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 300) check({name, "_timeout"}, 0, 1);
    @(posedge clk); #1;
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_idle_valid"}, out_valid, 0);
  endtask

  task automatic run_sweep(input logic [W-1:0] l, input logic [W-1:0] h, input int mode,
                           input string name);
    rdy_mode = mode;
    do_start(l, h);
    wait_idle(name);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      2: out_ready = 1'b0;
      default: begin
        if (out_valid && bin_out == W'(7) && stall_cnt < 3) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else begin
          out_ready = 1'b1;
        end
      end
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (hold_vld) begin
        check("hold_valid", out_valid, 1);
        check("hold_bin", bin_out, hold_bin);
        check("hold_gray", gray_out, hold_gray);
      end
      hold_vld = 0;
      if (exp_done) begin
        check("done_pulse", done, 1);
        check("valid_after_last", out_valid, 0);
        exp_done = 0;
      end else begin
        check("no_done", done, 0);
      end
      if (out_valid) begin
        check("busy_in_run", busy, 1);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", bin_out, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("beat_bin", bin_out, e.bin);
            check("beat_gray", gray_out, e.gray);
            if (e.last) exp_done = 1;
          end
        end else begin
          hold_vld  = 1;
          hold_bin  = bin_out;
          hold_gray = gray_out;
        end
      end
    end
  end

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; lo = '0; hi = '0; out_ready = 1'b0;
    build_gray_tab();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_bin", bin_out, 0);
    check("rst_gray", gray_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    run_sweep(4'd0, 4'd15, 0, "full");
`ifdef GRAY_SEQ_CHECK_EN
    check("chk_err_full", chk_err, 0);
`endif
    run_sweep(4'd13, 4'd2, 0, "wrap");
    stall_cnt = 0;
    run_sweep(4'd5, 4'd9, 3, "stall");
    check("stall_seen", stall_cnt, 3);

    rdy_mode = 2;
    do_start(4'd5, 4'd5);
    lo = 4'd0; hi = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ignored_start_busy", busy, 1);
    check("ignored_start_bin", bin_out, 5);
    rdy_mode = 0;
    wait_idle("single");
    check("single_drained", exp_q.size(), 0);

    rdy_mode = 0;
    do_start(4'd3, 4'd12);
    for (k = 0; k < 40; k++) begin
      if (out_valid && bin_out == W'(6)) break;
      @(posedge clk); #1;
    end
    if (k == 40) check("reach_bin6_timeout", 0, 1);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    exp_q.delete();
    exp_done = 0;
    hold_vld = 0;
    check("midrst_valid", out_valid, 0);
    check("midrst_bin", bin_out, 0);
    check("midrst_gray", gray_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    run_sweep(4'd2, 4'd4, 0, "after_rst");

    for (int i = 0; i < 8; i++)
      run_sweep(W'($urandom_range(0, N - 1)), W'($urandom_range(0, N - 1)), 1, "rand");

    check("final_queue", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
